// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and
// 32-cycle restoring divide on operand magnitudes, with sign fix-up on completion.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [5:0] LAST_CNT = 6'd32;

  state_t      state, state_nxt;
  logic [63:0] acc;      // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
  logic [31:0] opb;      // multiplicand or divisor magnitude
  logic [2:0]  op;
  logic [5:0]  cnt;
  logic        neg_q, neg_r, special;

  logic        a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] div_step;
  logic [63:0] prod;
  logic [31:0] quo, rem, fin_result;
  logic        finishing;

  // Operand decode for the request presented in IDLE.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    a_signed = 1'b0;
    b_signed = 1'b0;
    if (funct3[2]) begin
      a_signed = ~funct3[0];
      b_signed = ~funct3[0];
    end else begin
      a_signed = (funct3[1:0] != 2'b11);
      b_signed = ~funct3[1];
    end
    a_neg    = a_signed & rs1[31];
    b_neg    = b_signed & rs2[31];
    mag_a    = a_neg ? (32'd0 - rs1) : rs1;
    mag_b    = b_neg ? (32'd0 - rs2) : rs2;
    div_zero = (rs2 == 32'd0);
    div_ovf  = ~funct3[0] & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);
  end

  // One iteration of each algorithm.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    mul_step  = {mul_sum, acc[31:1]};
    div_shift = {acc[63:32], acc[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb};
    div_step  = div_diff[33] ? {div_shift[31:0], acc[30:0], 1'b0}
                             : {div_diff[31:0],  acc[30:0], 1'b1};
  end

  // Sign fix-up and result selection, used on the edge that enters DONE.
  always_comb begin
    prod = neg_q ? (64'd0 - acc) : acc;
    quo  = neg_q ? (32'd0 - acc[31:0])  : acc[31:0];
    rem  = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
    if (special)
      fin_result = acc[31:0];
    else if (op[2])
      fin_result = op[1] ? rem : quo;
    else
      fin_result = (op[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
  end

  assign finishing = ((state == MUL) || (state == DIV)) && (cnt == LAST_CNT);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = funct3[2] ? DIV : MUL;
      MUL:  if (cnt == LAST_CNT) state_nxt = DONE;
      DIV:  if (cnt == LAST_CNT) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      MUL, DIV: busy = 1'b1;
      DONE:     done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture and iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= 64'd0;
      opb     <= 32'd0;
      op      <= 3'd0;
      cnt     <= 6'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      special <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op      <= funct3;
          cnt     <= 6'd0;
          special <= 1'b0;
          opb     <= funct3[2] ? mag_b : mag_a;
          neg_q   <= a_neg ^ b_neg;
          neg_r   <= a_neg;
          if (funct3[2] && div_zero) begin
            // Divide by zero jumps straight to the final step with its fixed answer.
            acc     <= {32'd0, (funct3[1] ? rs1 : 32'hFFFF_FFFF)};
            special <= 1'b1;
            cnt     <= LAST_CNT;
          end else if (funct3[2] && div_ovf) begin
            acc     <= {32'd0, (funct3[1] ? 32'd0 : 32'h8000_0000)};
            special <= 1'b1;
            cnt     <= LAST_CNT;
          end else if (funct3[2]) begin
            acc <= {32'd0, mag_a};
          end else begin
            acc <= {32'd0, mag_b};
          end
        end
        MUL: if (cnt != LAST_CNT) begin
          acc <= mul_step;
          cnt <= cnt + 6'd1;
        end
        DIV: if (cnt != LAST_CNT) begin
          acc <= div_step;
          cnt <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Result only moves on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (rst)            result <= 32'd0;
    else if (finishing) result <= fin_result;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: results, latency, busy/done behaviour,
// dropped starts, mid-operation reset and back-to-back acceptance.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result;

  int vectors    = 0;
  int miscompares = 0;

  mul_div_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, then measure edges from acceptance to the done cycle.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic busy_ok;
    logic [31:0] held;
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, result, exp);
    check({tag, " busy while running"}, 32'(busy_ok), 32'd1);
    check({tag, " busy in done"}, 32'(busy), 32'd0);
    held = result;
    @(negedge clk);
    check({tag, " done one cycle"}, 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    check({tag, " result held"}, result, exp);
  endtask

  initial begin
    int n_done, done_at, d[4];
    logic [31:0] first_res;

    rst = 1'b1; start = 1'b0; funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy",   32'(busy), 32'd0);
    check("reset done",   32'(done), 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;

    run_op("MUL 5*6",          3'd0, 32'd5,          32'd6,          32'd30,          33);
    run_op("MUL -3*5",         3'd0, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,   33);
    run_op("DIV 5/6",          3'd4, 32'd5,          32'd6,          32'd0,           33);
    run_op("REM 5,6",          3'd6, 32'd5,          32'd6,          32'd5,           33);
    run_op("DIVU FFFFFFFE/2",  3'd5, 32'hFFFF_FFFE,  32'd2,          32'h7FFF_FFFF,   33);
    run_op("REM -7,2",         3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,   33);
    run_op("DIV -7/2",         3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,   33);
    run_op("REMU FFFFFFFF,10", 3'd7, 32'hFFFF_FFFF,  32'd10,         32'd5,           33);
    run_op("MULH -1*-1",       3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,   33);
    run_op("MULHU max*max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,   33);
    run_op("MULHSU -1,max",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,   33);
    run_op("MULHU 2^31*2",     3'd3, 32'h8000_0000,  32'd2,          32'd1,           33);
    run_op("DIV by zero",      3'd4, 32'd77,         32'd0,          32'hFFFF_FFFF,   1);
    run_op("REMU by zero",     3'd7, 32'h1234,       32'd0,          32'h1234,        1);
    run_op("DIV overflow",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,   1);
    run_op("REM overflow",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,   1);

    // A start pulse during a multiply must be dropped.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; rs1 = 32'd7; rs2 = 32'd9;
    @(negedge clk);
    start = 1'b0;
    n_done = 0; done_at = -1; first_res = 32'd0;
    for (int j = 0; j < 50; j++) begin
      if (done === 1'b1) begin
        n_done++;
        if (n_done == 1) begin done_at = j; first_res = result; end
      end
      if (j == 10) begin start = 1'b1; rs1 = 32'd100; rs2 = 32'd100; end
      if (j == 11) start = 1'b0;
      @(negedge clk);
    end
    check("mid-MUL start done count", 32'(n_done), 32'd1);
    check("mid-MUL start done time",  32'(done_at), 32'd33);
    check("mid-MUL start result",     first_res, 32'd63);

    // Reset during iteration 10 kills the op with no done pulse.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; rs1 = 32'h11; rs2 = 32'h22;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid-op reset busy",   32'(busy), 32'd0);
    check("mid-op reset done",   32'(done), 32'd0);
    check("mid-op reset result", result, 32'd0);
    rst = 1'b0;
    n_done = 0;
    for (int j = 0; j < 40; j++) begin
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    check("no done after reset", 32'(n_done), 32'd0);
    run_op("MUL 3*4 after reset", 3'd0, 32'd3, 32'd4, 32'd12, 33);

    // start held high: accepted only in IDLE, one done every 35 cycles.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; rs1 = 32'd7; rs2 = 32'd8;
    @(negedge clk);
    n_done = 0;
    for (int i = 0; i < 4; i++) d[i] = -1;
    for (int j = 0; j < 110; j++) begin
      if (done === 1'b1) begin
        if (n_done < 4) d[n_done] = j;
        n_done++;
        check("b2b result", result, 32'd56);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b done count",   32'(n_done), 32'd3);
    check("b2b first done",   32'(d[0]), 32'd33);
    check("b2b spacing 1",    32'(d[1] - d[0]), 32'd35);
    check("b2b spacing 2",    32'(d[2] - d[1]), 32'd35);
    repeat (45) @(negedge clk);
    check("idle after b2b busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have the port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port start, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have the port funct3, input, 3 bits: M-extension op. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 The block SHALL have the port rs1, input, 32 bits: operand A, i.e. multiplicand or dividend.
REQ-007 The block SHALL have the port rs2, input, 32 bits: operand B, i.e. multiplier or divisor.
REQ-008 The block SHALL have the port busy, output, 1 bit: high while an accepted operation is not yet complete; core stalls on it.
REQ-009 The block SHALL have the port done, output, 1 bit: single-cycle pulse; result is valid in the same cycle.
REQ-010 The block SHALL have the port result, output, 32 bits: rd write-back value; held until the next accepted start.

Function
REQ-011 The FSM SHALL have states IDLE, MUL, DIV, DONE; reset and power-up state is IDLE.
REQ-012 In IDLE, start=1 SHALL latch funct3, rs1 and rs2 and set busy=1 on the same edge.
- funct3[2]=0 -> MUL.
- funct3[2]=1 -> DIV, except the cases in REQ-017/018.
REQ-013 Inputs SHALL be ignored while busy=1; a start during busy is dropped, not queued.
REQ-014 MUL SHALL be a 32-iteration shift-add on operand magnitudes using a 64-bit product register; exactly 32 cycles, then DONE.
- Operand signedness: MUL/MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU both unsigned.
- The 64-bit product SHALL be negated when exactly one signed-treated operand is negative.
- MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
REQ-015 DIV SHALL be a 32-iteration restoring division on magnitudes (one quotient bit per cycle); exactly 32 cycles, then DONE.
- DIV/REM treat operands as signed; DIVU/REMU treat them as unsigned.
- Quotient is negated when operand signs differ.
- Remainder takes the sign of the dividend.
- DIV/DIVU return the quotient; REM/REMU return the remainder.
REQ-016 Normal latency SHALL be fixed: start accepted at edge k -> done=1 and result valid in the cycle following edge k+33; busy is high from edge k through edge k+33; IDLE is re-entered at edge k+34.
REQ-017 Divide by zero (rs2=0) SHALL skip iteration and go directly to DONE: done in the cycle after edge k+1.
- DIV/DIVU -> 0xFFFFFFFF.
- REM/REMU -> rs1.
- No trap.
REQ-018 Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF) SHALL also take the one-cycle path.
- DIV -> 0x80000000.
- REM -> 0x00000000.
REQ-019 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE unconditionally.
- start asserted in DONE is ignored.
- The next operation can be accepted in the following IDLE cycle.
REQ-020 result SHALL change only on the edge entering DONE and stay stable until the next operation reaches DONE.
REQ-021 All arithmetic SHALL be exact modulo 2^32 per RISC-V M-spec; no rounding other than truncation toward zero for division.

Reset
REQ-022 rst=1 at any rising edge SHALL force IDLE, busy=0, done=0, result=0x00000000, and clear the iteration counter and internal registers, including mid-operation.
REQ-023 An operation interrupted by reset SHALL produce no done pulse.
- The first start after rst deasserts SHALL behave per REQ-016.

Verification
REQ-024 The bench SHALL cover:
- MUL rs1=5, rs2=6 -> result=30; done exactly 33 cycles after start edge; busy high throughout.
- DIV 5/6 -> 0; REM 5,6 -> 5; DIVU 0xFFFFFFFE/2 -> 0x7FFFFFFF; REM -7,2 -> 0xFFFFFFFF (-1).
- MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFF.
- DIV rs2=0 -> 0xFFFFFFFF and REMU rs1=0x1234,rs2=0 -> 0x1234, each with done one cycle after start edge; DIV 0x80000000/-1 -> 0x80000000.
- A second start pulse mid-MUL is ignored (single done, first result); rst asserted at iteration 10 -> busy=0, done never pulses, result=0; a following MUL 3*4 -> 12 with normal latency.
- Back-to-back: start held high continuously -> operations accepted only in IDLE, one done per op, spacing 35 cycles.
